// File: rtl/multimode_shift_counter_if.sv
// multimode_shift_counter_if: control and status bundle for the multimode shift counter
interface multimode_shift_counter_if #(parameter int WIDTH = 8);
  logic en;
  logic [1:0] mode;
  logic dir;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic wrap;
  logic err;
  modport master(output en, mode, dir, load, load_val, input count, wrap, err);
  modport slave(input en, mode, dir, load, load_val, output count, wrap, err);
endinterface

// File: rtl/multimode_shift_counter.sv
// multimode_shift_counter: ring/Johnson/LFSR sequence generator with load, wrap pulse and illegal-state recovery
module multimode_shift_counter #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8)
) (
  input logic clk,
  input logic reset,
  multimode_shift_counter_if.slave bus
);
  logic [WIDTH-1:0] count_q, seed, nxt;
  logic [WIDTH-2:0] jd;
  logic [1:0] mode_q;
  logic wrap_q, err_q, legal;
  always_comb begin
    jd = count_q[WIDTH-2:0] ^ count_q[WIDTH-1:1];
    seed = bus.mode == 2'b01 ? '0 : bus.mode == 2'b11 ? count_q : WIDTH'(1);
    nxt = bus.mode == 2'b10 ? {count_q[WIDTH-2:0], ^(count_q & TAPS)} :
          bus.mode == 2'b01 ? (bus.dir ? {~count_q[0], count_q[WIDTH-1:1]} : {count_q[WIDTH-2:0], ~count_q[WIDTH-1]}) :
          (bus.dir ? {count_q[0], count_q[WIDTH-1:1]} : {count_q[WIDTH-2:0], count_q[WIDTH-1]});
    // Johnson is legal when the bit pattern has at most one 0/1 boundary
    legal = bus.mode == 2'b10 ? |count_q :
            bus.mode == 2'b01 ? (jd & (jd - (WIDTH-1)'(1))) == '0 :
            count_q != '0 && (count_q & (count_q - WIDTH'(1))) == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= WIDTH'(1);
      mode_q <= 2'b00;
      wrap_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q <= 1'b0;
      if (bus.load) begin
        count_q <= bus.load_val;
        mode_q <= bus.mode;
      end else if (bus.mode != mode_q) begin
        count_q <= seed;
        mode_q <= bus.mode;
      end else if (bus.en && bus.mode != 2'b11) begin
        count_q <= legal ? nxt : seed;
        err_q <= !legal;
        wrap_q <= legal && nxt == seed;
      end
    end
  end
  assign bus.count = count_q;
  assign bus.wrap = wrap_q;
  assign bus.err = err_q;
endmodule

// File: doc/multimode_shift_counter.md
Name: multimode_shift_counter

Overview:
Parametrised shift-register counter generalising the 8-bit fixed-pattern shift counter. It supports ring (one-hot), Johnson (twisted-ring) and LFSR sequences, left/right direction, count enable, parallel load, a wrap pulse and illegal-state self-correction. It is the standard sequence/phase generator for sequencing and pattern-generation logic in the homework designs.

Parameters:
WIDTH, 8, counter width in bits; legal range 3..32.
TAPS, 8'hB8, LFSR feedback mask of WIDTH bits; the default gives period 255 at WIDTH=8.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  advance one step per clock when high
mode  input  2  00 ring, 01 Johnson, 10 LFSR, 11 hold
dir  input  1  0 shift left (toward MSB), 1 shift right; ignored in LFSR mode
load  input  1  parallel load strobe
load_val  input  WIDTH  value for parallel load
count  output  WIDTH  current counter state, registered
wrap  output  1  one-cycle pulse: a step has just returned count to the seed
err  output  1  one-cycle pulse: a step found an illegal state and replaced it with the seed

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset. There is no asynchronous path.
- Seeds:
  - ring: {0...0,1}
  - Johnson: all zeros
  - LFSR: {0...0,1}
  - hold: count is unchanged
- Reset: count={0...0,1}, wrap=0, err=0, internal mode register=00 (ring).
- Internal register mode_q holds the mode from the previous cycle.
- Per-edge priority, highest first:
  - reset
  - load: count<=load_val verbatim (even if illegal); mode_q<=mode.
  - mode!=mode_q: count<=seed(mode); mode_q<=mode.
  - en and mode!=11: step.
  - otherwise: hold.
- wrap and err are 0 after every edge except a step edge that sets them.
- Step, ring mode:
  - left: count<={count[W-2:0],count[W-1]}.
  - right: count<={count[0],count[W-1:1]}.
  - Legal iff exactly one bit is set.
- Step, Johnson mode:
  - left: count<={count[W-2:0],~count[W-1]}.
  - right: count<={~count[0],count[W-1:1]}.
  - Legal iff adjacent bits differ at most once (patterns 0*1* or 1*0*).
- Step, LFSR mode: count<={count[W-2:0],^(count&TAPS)}. Legal iff count!=0.
- Illegal state at a step edge: count<=seed(mode), err=1, wrap=0. Correction costs exactly one step.
- wrap=1 after a legal step whose result equals seed(mode).
- Periods:
  - ring: WIDTH steps.
  - Johnson: 2*WIDTH steps.
  - LFSR: 2^WIDTH-1 steps for a primitive TAPS.
- Changing dir mid-sequence takes effect on the next step with no reload. The reversed sequence is legal for both ring and Johnson.
- Simultaneous load and mode change: load wins; the new mode is latched without reseeding.
- Reset asserted mid-sequence: takes effect at the next edge regardless of en, load or mode.
- mode=11 with en=1: count holds; no wrap, no err.

Test Plan:
1. Reset, then ring, dir=0, en=1, 8 clocks -> count 00000010,00000100,...,10000000,00000001; wrap=1 only on the 8th step.
2. mode 00->01, en=1, 16 steps -> reseed to 00000000 with no wrap; sequence 00000001,00000011,...,11111111,11111110,...,10000000,00000000; wrap=1 on step 16.
3. Ring, load=1 with load_val=8'b00100100, then one step -> count=00100100, then 00000001 with err=1 and wrap=0; err clears on the next cycle.
4. LFSR from seed 1, en=1, 255 clocks -> count never 0 and no repeat before step 255; count=00000001 and wrap=1 at step 255. Load 0 then step -> 00000001 with err=1.
5. Ring at 00010000: dir=1 step -> 00001000; dir=0 step -> 00010000. en=0 for 3 clocks -> count holds, wrap=0.
6. reset=1 coincident with load=1 and en=1 mid-Johnson -> count=00000001, wrap=0, err=0, mode register=ring; with mode input still 01, the next edge reseeds to 00000000.
